dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Memory-stage responder for the pipeline's M-stage control bundle (MemWriteM, ResultSrcM-derived read enable, ALU address, store data).
- Direct-mapped, one-word-line, write-through, no-write-allocate data cache.
- Serves load hits in the same cycle and forwards misses and all stores to a handshaked main-memory port.
- Raises StallM to freeze the pipeline while a memory transaction is outstanding.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width; line = one word.
- SETS, 64, number of lines; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- MemReadM  in  1  load request; asserted upstream when ResultSrcM = 2'b01.
- MemWriteM  in  1  store request.
- ALUResultM  in  ADDR_WIDTH  byte address, word-aligned; bits [1:0] ignored.
- WriteDataM  in  DATA_WIDTH  store data.
- ReadDataM  out  DATA_WIDTH  load data.
- StallM  out  1  pipeline freeze request.
- MemReq  out  1  memory request valid.
- MemWe  out  1  1 = write, 0 = read; valid with MemReq.
- MemAddr  out  ADDR_WIDTH  memory word address (byte address, [1:0] = 0).
- MemWData  out  DATA_WIDTH  memory write data.
- MemRData  in  DATA_WIDTH  memory read data; valid when MemReady = 1.
- MemReady  in  1  memory completion; meaningful only while MemReq = 1.

Behaviour:
- Address split: offset = [1:0]; index = [2 +: log2(SETS)]; tag = remaining upper bits.
- Hit = valid[index] and tag match.
- Reset (synchronous, rst = 1 at a clk edge):
  - all valid bits cleared; state <- IDLE.
  - outputs: MemReq = 0, MemWe = 0, MemAddr = 0, MemWData = 0, StallM = 0, ReadDataM = 0.
  - tag and data arrays are not reset.
  - rst mid-transaction abandons the transaction: MemReq low from the next cycle, no line fill, no later MemReady acted upon.
- FSM states: IDLE, RD_MISS, WR_THRU.
- IDLE:
  - Load hit: ReadDataM = line data combinationally in the same cycle; StallM = 0; no state change.
  - Load miss: StallM = 1; capture address; next state RD_MISS.
  - Store (hit or miss): StallM = 1; capture address and data; next state WR_THRU.
  - If MemWriteM and MemReadM are both asserted, the store takes priority and the load is ignored.
  - Neither asserted: StallM = 0; ReadDataM = 0.
- RD_MISS:
  - MemReq = 1, MemWe = 0, MemAddr = captured address.
  - While MemReady = 0: StallM = 1.
  - On MemReady = 1: StallM = 0, ReadDataM = MemRData in that same cycle; line written (data, tag, valid = 1) at the clock edge; next state IDLE.
- WR_THRU:
  - MemReq = 1, MemWe = 1, MemAddr and MemWData = captured values.
  - StallM = 1 until MemReady = 1; StallM = 0 in the MemReady cycle.
  - If the captured address hit at capture time, the line data is updated on the MemReady edge.
  - Misses do not allocate. Next state IDLE.
- MemReq, MemWe, MemAddr and MemWData are driven from registers and held stable until the MemReady cycle.
- MemReady while MemReq = 0 is ignored.
- Minimum miss and store cost: 2 cycles (detect cycle plus a MemReady cycle). Back-to-back requests are accepted in the IDLE cycle that follows completion.
- Index aliasing (same index, different tag): a read fill overwrites the line.

Optional Feature:
- Macro DCACHE_STATS_EN.
- Defined:
  - adds outputs HitCount and MissCount, both 32 bits, reset to 0.
  - HitCount += 1 per IDLE load hit.
  - MissCount += 1 per IDLE load miss.
  - Both counters wrap modulo 2^32; stores are not counted.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- dcache_pkg holds:
  - enum dcache_state_t {IDLE, RD_MISS, WR_THRU}.
  - localparam functions for INDEX_W = $clog2(SETS) and TAG_W = ADDR_WIDTH - INDEX_W - 2.
- Sub-module dcache_array holds the valid vector (with synchronous clear), tag RAM and data RAM.
  - One combinational read port.
  - One write port with separate data-write and tag/valid-write enables.
- dcache_ctrl contains the FSM and capture registers.

Test Plan:
- Cold load: after rst, load 0x100 with MemRData = 0xDEADBEEF and MemReady after 3 cycles -> StallM high 3 cycles and low in the MemReady cycle; ReadDataM = 0xDEADBEEF; MissCount = 1.
- Warm hit: load 0x100 again -> same cycle ReadDataM = 0xDEADBEEF, StallM = 0, MemReq = 0; HitCount = 1.
- Store hit: store 0x12345678 to 0x100 -> MemReq = 1, MemWe = 1, MemAddr = 0x100, MemWData = 0x12345678; following load of 0x100 hits and returns 0x12345678.
- Store miss: store to 0x200 -> memory write issued; subsequent load of 0x200 misses (no allocate).
- Alias: with SETS = 64, load 0x100, then load 0x200 (same index 0) -> second load misses and refills; reload of 0x100 misses again.
- Reset mid-miss: assert rst during RD_MISS before MemReady -> MemReq = 0 next cycle, StallM = 0; load of 0x100 misses (valid bits cleared).
- Simultaneous MemReadM and MemWriteM -> only a write transaction is issued.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the direct-mapped write-through data cache.
package dcache_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RD_MISS,
      WR_THRU
   } dcache_state_t;

   function automatic int calcIndexW(input int sets);
      return $clog2(sets);
   endfunction

   // Tag covers everything above the 2-bit byte offset and the index field.
   function automatic int calcTagW(input int addrWidth, input int sets);
      return addrWidth - $clog2(sets) - 2;
   endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid vector, tag RAM and data RAM: one combinational read port, one write port.
module dcache_array
   import dcache_pkg::*;
#(
   parameter int SETS       = 64,
   parameter int DATA_WIDTH = 32,
   parameter int INDEX_W    = 6,
   parameter int TAG_W      = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INDEX_W-1:0]    rdIndex,
   output logic                  rdValid,
   output logic [TAG_W-1:0]      rdTag,
   output logic [DATA_WIDTH-1:0] rdData,
   input  logic [INDEX_W-1:0]    wrIndex,
   input  logic                  dataWe,
   input  logic                  tagWe,
   input  logic [TAG_W-1:0]      wrTag,
   input  logic [DATA_WIDTH-1:0] wrData
);

   logic [SETS-1:0]       validBits;
   logic [TAG_W-1:0]      tagRam  [SETS];
   logic [DATA_WIDTH-1:0] dataRam [SETS];

   always_ff @(posedge clk) begin
      if (rst)
         validBits <= '0;
      else if (tagWe)
         validBits[wrIndex] <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (tagWe)
         tagRam[wrIndex] <= wrTag;
      if (dataWe)
         dataRam[wrIndex] <= wrData;
   end

   assign rdValid = validBits[rdIndex];
   assign rdTag   = tagRam[rdIndex];
   assign rdData  = dataRam[rdIndex];

endmodule

// File: rtl/dcache_ctrl.sv
// M-stage data cache controller: same-cycle load hits, handshaked misses and write-through stores.
// Optional hit/miss counters enabled with DCACHE_STATS_EN.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int SETS       = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  MemReadM,
   input  logic                  MemWriteM,
   input  logic [ADDR_WIDTH-1:0] ALUResultM,
   input  logic [DATA_WIDTH-1:0] WriteDataM,
   output logic [DATA_WIDTH-1:0] ReadDataM,
   output logic                  StallM,
   output logic                  MemReq,
   output logic                  MemWe,
   output logic [ADDR_WIDTH-1:0] MemAddr,
   output logic [DATA_WIDTH-1:0] MemWData,
   input  logic [DATA_WIDTH-1:0] MemRData,
   input  logic                  MemReady
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]           HitCount,
   output logic [31:0]           MissCount
`endif
);

   localparam int INDEX_W = calcIndexW(SETS);
   localparam int TAG_W   = calcTagW(ADDR_WIDTH, SETS);

   dcache_state_t         state;
   logic                  hitCap;
   logic [ADDR_WIDTH-1:0] wordAddr;
   logic                  rdValid;
   logic [TAG_W-1:0]      rdTag;
   logic [DATA_WIDTH-1:0] rdData;
   logic                  hit;
   logic                  done;
   logic                  dataWe;
   logic                  tagWe;
   logic [DATA_WIDTH-1:0] wrData;

   assign wordAddr = ALUResultM & {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
   assign hit      = rdValid && (rdTag == wordAddr[ADDR_WIDTH-1 -: TAG_W]);
   assign done     = !rst && MemReq && MemReady;

   // The registered MemAddr doubles as the captured address for the line write.
   assign tagWe  = done && (state == RD_MISS);
   assign dataWe = done && ((state == RD_MISS) || ((state == WR_THRU) && hitCap));
   assign wrData = (state == RD_MISS) ? MemRData : MemWData;

   dcache_array #(
      .SETS       (SETS),
      .DATA_WIDTH (DATA_WIDTH),
      .INDEX_W    (INDEX_W),
      .TAG_W      (TAG_W)
   ) uArray (
      .clk     (clk),
      .rst     (rst),
      .rdIndex (wordAddr[2 +: INDEX_W]),
      .rdValid (rdValid),
      .rdTag   (rdTag),
      .rdData  (rdData),
      .wrIndex (MemAddr[2 +: INDEX_W]),
      .dataWe  (dataWe),
      .tagWe   (tagWe),
      .wrTag   (MemAddr[ADDR_WIDTH-1 -: TAG_W]),
      .wrData  (wrData)
   );

   always_comb begin
      StallM    = 1'b0;
      ReadDataM = '0;
      if (!rst) begin
         unique case (state)
            IDLE: begin
               if (MemWriteM)
                  StallM = 1'b1;
               else if (MemReadM) begin
                  if (hit)
                     ReadDataM = rdData;
                  else
                     StallM = 1'b1;
               end
            end
            RD_MISS: begin
               if (MemReady)
                  ReadDataM = MemRData;
               else
                  StallM = 1'b1;
            end
            WR_THRU: StallM = !MemReady;
            default: StallM = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         MemReq   <= 1'b0;
         MemWe    <= 1'b0;
         MemAddr  <= '0;
         MemWData <= '0;
         hitCap   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (MemWriteM) begin
                  state    <= WR_THRU;
                  MemReq   <= 1'b1;
                  MemWe    <= 1'b1;
                  MemAddr  <= wordAddr;
                  MemWData <= WriteDataM;
                  hitCap   <= hit;
               end else if (MemReadM && !hit) begin
                  state   <= RD_MISS;
                  MemReq  <= 1'b1;
                  MemWe   <= 1'b0;
                  MemAddr <= wordAddr;
               end
            end
            RD_MISS, WR_THRU: begin
               if (MemReady) begin
                  state  <= IDLE;
                  MemReq <= 1'b0;
                  MemWe  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DCACHE_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         HitCount  <= '0;
         MissCount <= '0;
      end else if ((state == IDLE) && MemReadM && !MemWriteM) begin
         if (hit)
            HitCount <= HitCount + 32'd1;
         else
            MissCount <= MissCount + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl; counter checks compiled in with DCACHE_STATS_EN.
module tb_dcache_ctrl;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [31:0] MemRData;
  logic        MemReady;
`ifdef DCACHE_STATS_EN
  logic [31:0] HitCount;
  logic [31:0] MissCount;
`endif

  int checks = 0;
  int errors = 0;
  int expHits = 0;
  int expMisses = 0;
  logic [31:0] loadQ[$];
  txn_t        txnQ[$];
  logic [31:0] mData [64];

  always #5 clk = ~clk;

  dcache_ctrl #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .SETS       (64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .MemReq     (MemReq),
    .MemWe      (MemWe),
    .MemAddr    (MemAddr),
    .MemWData   (MemWData),
    .MemRData   (MemRData),
    .MemReady   (MemReady)
`ifdef DCACHE_STATS_EN
    ,
    .HitCount   (HitCount),
    .MissCount  (MissCount)
`endif
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic doLoad(input logic [31:0] addr, input logic expHit, input logic [31:0] memData,
                        input int waitCycles, input string name);
    logic [31:0] exp;
    int          stalls;
    int          idx;
    idx = int'(addr[7:2]);
    @(posedge clk); #1;
    MemReadM = 1'b1; MemWriteM = 1'b0; ALUResultM = addr; WriteDataM = '0;
    MemReady = 1'b0; MemRData = '0;
    loadQ.push_back(expHit ? mData[idx] : memData);
    @(negedge clk);
    stalls = int'(StallM);
    if (expHit) begin
      expHits++;
      exp = loadQ.pop_front();
      checks++;
      if (StallM !== 1'b0 || MemReq !== 1'b0) begin
        errors++;
        $display("FAIL %s hit stall/req: StallM=%b MemReq=%b required 0/0", name, StallM, MemReq);
      end
      checks++;
      if (ReadDataM !== exp) begin
        errors++;
        $display("FAIL %s hit data: got %h required %h", name, ReadDataM, exp);
      end
    end else begin
      expMisses++;
      checks++;
      if (StallM !== 1'b1) begin
        errors++;
        $display("FAIL %s miss detect stall: got %b required 1", name, StallM);
      end
      for (int i = 0; i < waitCycles; i++) begin
        @(posedge clk); #1;
        @(negedge clk);
        stalls += int'(StallM);
        checks++;
        if (MemReq !== 1'b1 || MemWe !== 1'b0 || MemAddr !== addr) begin
          errors++;
          $display("FAIL %s read req: req=%b we=%b addr=%h required 1/0/%h",
                   name, MemReq, MemWe, MemAddr, addr);
        end
      end
      @(posedge clk); #1;
      MemReady = 1'b1; MemRData = memData;
      @(negedge clk);
      exp = loadQ.pop_front();
      checks++;
      if (StallM !== 1'b0 || MemReq !== 1'b1) begin
        errors++;
        $display("FAIL %s ready cycle: StallM=%b MemReq=%b required 0/1", name, StallM, MemReq);
      end
      checks++;
      if (ReadDataM !== exp) begin
        errors++;
        $display("FAIL %s miss data: got %h required %h", name, ReadDataM, exp);
      end
      checks++;
      if (stalls != waitCycles + 1) begin
        errors++;
        $display("FAIL %s stall cycles: got %0d required %0d", name, stalls, waitCycles + 1);
      end
      mData[idx] = memData;
    end
  endtask

  task automatic doStore(input logic [31:0] addr, input logic [31:0] data, input logic alsoRead,
                         input logic expHit, input int waitCycles, input string name);
    txn_t t;
    int   idx;
    idx = int'(addr[7:2]);
    @(posedge clk); #1;
    MemReadM = alsoRead; MemWriteM = 1'b1; ALUResultM = addr; WriteDataM = data;
    MemReady = 1'b0; MemRData = 32'hFFFF_0000;
    txnQ.push_back('{we: 1'b1, addr: addr, data: data});
    @(negedge clk);
    checks++;
    if (StallM !== 1'b1 || MemReq !== 1'b0) begin
      errors++;
      $display("FAIL %s detect: StallM=%b MemReq=%b required 1/0", name, StallM, MemReq);
    end
    for (int i = 0; i <= waitCycles; i++) begin
      @(posedge clk); #1;
      MemReadM = 1'b0; MemWriteM = 1'b0; WriteDataM = '0;
      MemReady = (i == waitCycles);
      @(negedge clk);
      t = txnQ[0];
      checks++;
      if (MemReq !== 1'b1 || MemWe !== t.we || MemAddr !== t.addr || MemWData !== t.data) begin
        errors++;
        $display("FAIL %s write txn: req=%b we=%b addr=%h wdata=%h required 1/%b/%h/%h",
                 name, MemReq, MemWe, MemAddr, MemWData, t.we, t.addr, t.data);
      end
      checks++;
      if (StallM !== (i != waitCycles)) begin
        errors++;
        $display("FAIL %s stall cycle %0d: got %b required %b", name, i, StallM, i != waitCycles);
      end
    end
    void'(txnQ.pop_front());
    if (expHit)
      mData[idx] = data;
  endtask

  task automatic idleCycle();
    @(posedge clk); #1;
    MemReadM = 1'b0; MemWriteM = 1'b0; MemReady = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b0; ALUResultM = '0; WriteDataM = '0;
    MemRData = '0; MemReady = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (MemReq !== 1'b0 || MemWe !== 1'b0 || MemAddr !== 32'h0 || MemWData !== 32'h0) begin
      errors++;
      $display("FAIL reset mem port: req=%b we=%b addr=%h wdata=%h required 0", MemReq, MemWe, MemAddr, MemWData);
    end
    checks++;
    if (StallM !== 1'b0 || ReadDataM !== 32'h0) begin
      errors++;
      $display("FAIL reset outputs: StallM=%b ReadDataM=%h required 0", StallM, ReadDataM);
    end
  endtask

  task automatic test_load_paths();
    doLoad(32'h100, 1'b0, 32'hDEADBEEF, 2, "cold_load");
    doLoad(32'h100, 1'b1, 32'h0, 0, "warm_hit");
    doLoad(32'h103, 1'b1, 32'h0, 0, "offset_ignored");
  endtask

  task automatic test_stores();
    doStore(32'h100, 32'h12345678, 1'b0, 1'b1, 1, "store_hit");
    doLoad(32'h100, 1'b1, 32'h0, 0, "load_after_store_hit");
    doStore(32'h200, 32'hCAFEF00D, 1'b0, 1'b0, 0, "store_miss");
    doLoad(32'h200, 1'b0, 32'h0BADF00D, 1, "load_after_store_miss");
  endtask

  task automatic test_alias();
    doLoad(32'h100, 1'b0, 32'h11112222, 1, "alias_reload_100");
    doLoad(32'h200, 1'b0, 32'h33334444, 0, "alias_reload_200");
    doLoad(32'h200, 1'b1, 32'h0, 0, "alias_hit_200");
  endtask

  task automatic test_reset_mid_miss();
    doLoad(32'h104, 1'b0, 32'h0000A0A0, 0, "fill_104");
    doLoad(32'h100, 1'b0, 32'h11112222, 0, "fill_100");
    @(posedge clk); #1;
    MemReadM = 1'b1; MemWriteM = 1'b0; ALUResultM = 32'h180; MemReady = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (MemReq !== 1'b1 || StallM !== 1'b1) begin
      errors++;
      $display("FAIL abandon pre-reset: req=%b stall=%b required 1/1", MemReq, StallM);
    end
    @(posedge clk); #1;
    rst = 1'b1; MemReadM = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; MemReady = 1'b1; MemRData = 32'hBAD0BAD0;
    @(negedge clk);
    checks++;
    if (MemReq !== 1'b0 || StallM !== 1'b0 || MemWe !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_miss: req=%b stall=%b we=%b required 0/0/0", MemReq, StallM, MemWe);
    end
    expHits = 0;
    expMisses = 0;
    doLoad(32'h100, 1'b0, 32'h55556666, 0, "post_reset_100");
    doLoad(32'h104, 1'b0, 32'h77778888, 1, "post_reset_104");
    doLoad(32'h180, 1'b0, 32'h9999AAAA, 0, "post_reset_180");
  endtask

  task automatic test_back_to_back();
    doStore(32'h100, 32'hA5A5A5A5, 1'b1, 1'b1, 1, "simul_rd_wr");
    doLoad(32'h100, 1'b1, 32'h0, 0, "after_simul");
    doLoad(32'h108, 1'b0, 32'h01020304, 0, "b2b_miss");
    doStore(32'h108, 32'h0A0B0C0D, 1'b0, 1'b1, 0, "b2b_store");
    doLoad(32'h108, 1'b1, 32'h0, 0, "b2b_hit");
    idleCycle();
    @(negedge clk);
    checks++;
    if (MemReq !== 1'b0 || StallM !== 1'b0 || ReadDataM !== 32'h0) begin
      errors++;
      $display("FAIL idle outputs: req=%b stall=%b data=%h required 0/0/0", MemReq, StallM, ReadDataM);
    end
  endtask

  initial begin
    test_reset();
    test_load_paths();
    test_stores();
    test_alias();
    test_reset_mid_miss();
`ifdef DCACHE_STATS_EN
    @(negedge clk);
    checks++;
    if (HitCount !== 32'(expHits) || MissCount !== 32'(expMisses)) begin
      errors++;
      $display("FAIL stats: hit=%0d miss=%0d required %0d/%0d", HitCount, MissCount, expHits, expMisses);
    end
`endif
    test_back_to_back();
    checks++;
    if (loadQ.size() != 0 || txnQ.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: loads=%0d txns=%0d required 0/0", loadQ.size(), txnQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
